mul_scheduler: RTL

//  Upstream stage of the 32x32 nibble-serial multiplier. Buffers operand pairs in a small FIFO,

---
 rtl/mul_scheduler_pkg.sv | 21 ++
 rtl/mul_scheduler_if.sv | 41 ++++
 rtl/mul_scheduler_op_fifo.sv | 59 +++++
 rtl/mul_scheduler.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mul_scheduler_pkg.sv
// Shared types for the multiplier scheduler slice.
// Widths and the scheduler FSM encoding live here.
package mul_scheduler_pkg;

  localparam int OP_W  = 32;
  localparam int RES_W = 64;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } sched_state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_t;

endpackage

// File: rtl/mul_scheduler_if.sv
// Operand, multiplier and product handshakes of the scheduler.
// slave = scheduler side, master = environment side.
interface mul_scheduler_if;
  import mul_scheduler_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic             mul_valid_in;
  logic [OP_W-1:0]  mul_a;
  logic [OP_W-1:0]  mul_b;
  logic             mul_valid_out;
  logic [RES_W-1:0] mul_r;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_r;
  logic [CNT_W-1:0] done_cnt;
  logic             err;

  modport slave (
    input  in_valid, in_a, in_b,
    input  mul_valid_out, mul_r,
    input  out_ready,
    output in_ready,
    output mul_valid_in, mul_a, mul_b,
    output out_valid, out_r,
    output done_cnt, err
  );

  modport master (
    output in_valid, in_a, in_b,
    output mul_valid_out, mul_r,
    output out_ready,
    input  in_ready,
    input  mul_valid_in, mul_a, mul_b,
    input  out_valid, out_r,
    input  done_cnt, err
  );

endinterface

// File: rtl/mul_scheduler_op_fifo.sv
// Synchronous operand FIFO, DEPTH x {a,b}.
// Extra pointer bit distinguishes full from empty.
module mul_scheduler_op_fifo
  import mul_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  op_t  wdata_i,
  input  logic pop_i,
  output op_t  rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  op_t           mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] wptr_d;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] rptr_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + PW'(do_push);
    rptr_d = rptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // storage needs no reset; emptiness is carried by the pointers
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Issues buffered operand pairs to a non-pipelined multiplier
// one at a time and returns products in order on ready/valid.
module mul_scheduler
  import mul_scheduler_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 12
) (
  input logic            clk,
  input logic            rst,
  mul_scheduler_if.slave bus
);

  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  sched_state_t     state_q;
  sched_state_t     state_d;
  logic [WW-1:0]    wait_q;
  logic [WW-1:0]    wait_d;
  logic [RES_W-1:0] out_r_q;
  logic [RES_W-1:0] out_r_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [CNT_W-1:0] done_q;
  logic [CNT_W-1:0] done_d;
  logic             err_q;
  logic             err_d;

  logic issue;
  logic pop;
  logic full;
  logic empty;
  op_t  wr_op;
  op_t  head;

  assign wr_op.a = bus.in_a;
  assign wr_op.b = bus.in_b;

  mul_scheduler_op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid),
    .wdata_i (wr_op),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    out_r_d     = out_r_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;
    err_d       = err_q;
    issue       = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        // mul_valid_out may be stale or unknown here
        if (!empty) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
        pop     = 1'b1;
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mul_valid_out) begin
          out_r_d     = bus.mul_r;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          done_d      = done_q + CNT_W'(1);
          state_d     = empty ? IDLE : ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      done_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready     = !full;
  assign bus.mul_valid_in = issue && !rst;
  assign bus.mul_a        = head.a;
  assign bus.mul_b        = head.b;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_r        = out_r_q;
  assign bus.done_cnt     = done_q;
  assign bus.err          = err_q;

endmodule
